float_to_fixed: RTL and testbench

Converts an IEEE-754 single-precision value to a 32-bit two's-complement fixed-point integer scaled by a signed power-of-two exponent, so that fixed = trunc(float / 2^exp_in).
It is the inverse of the team's fixed-to-float converter, which computes fixed * 2^exp -> float, and sits beside it in the FPU datapath.
It is multi-cycle: a one-bit-per-cycle iterative shifter behind a load/busy/done handshake.

---
 rtl/float_to_fixed_if.sv | 26 ++
 rtl/float_to_fixed.sv | 141 ++++++++++++++
 tb/tb_float_to_fixed.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_fixed_if.sv
`default_nettype none
// ============================================================================
// Module      : float_to_fixed_if
// Description : Operand/result handshake bundle for the float-to-fixed converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface float_to_fixed_if;
  logic [31:0] float_in;
  logic [7:0]  exp_in;
  logic        load_new;
  logic [31:0] fixed;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output float_in, exp_in, load_new,
    input  fixed, busy, done, overflow
  );

  modport slave (
    input  float_in, exp_in, load_new,
    output fixed, busy, done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/float_to_fixed.sv
`default_nettype none
// ============================================================================
// Module      : float_to_fixed
// Description : Iterative IEEE-754 single to 32-bit fixed converter,
//               fixed = trunc(float / 2^exp_in), one shift bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_fixed (
  input  wire logic         clk,
  input  wire logic         reset,
  float_to_fixed_if.slave   ctl
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_SHIFT  = 2'd2,
    S_SIGN   = 2'd3
  } state_t;

  localparam logic [31:0] c_pos_sat = 32'h7FFF_FFFF;
  localparam logic [31:0] c_neg_sat = 32'h8000_0000;

  state_t      r_state;
  logic [31:0] r_float;
  logic [7:0]  r_exp;
  logic [31:0] r_mag;
  logic [4:0]  r_cnt;
  logic        r_left;
  logic        r_sat;
  logic [31:0] r_fixed;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;

  logic              w_sign;
  logic [7:0]        w_e;
  logic [22:0]       w_mant;
  logic [23:0]       w_sig;
  logic signed [9:0] w_k;
  logic [4:0]        w_rn;
  logic [31:0]       w_sat_val;
  logic              w_exact_min;

  logic [31:0] w_dec_mag;
  logic [4:0]  w_dec_n;
  logic        w_dec_left;
  logic        w_dec_sat;

  assign w_sign      = r_float[31];
  assign w_e         = r_float[30:23];
  assign w_mant      = r_float[22:0];
  assign w_sig       = {1'b1, w_mant};
  // Net binary-point shift: positive means shift left, negative means right.
  assign w_k         = $signed({2'b00, w_e}) - 10'sd150 - $signed({{2{r_exp[7]}}, r_exp});
  assign w_rn        = 5'(10'sd0 - w_k);
  assign w_sat_val   = w_sign ? c_neg_sat : c_pos_sat;
  assign w_exact_min = w_sign && (w_mant == 23'd0);

  always_comb begin
    w_dec_mag  = 32'd0;
    w_dec_n    = 5'd0;
    w_dec_left = 1'b0;
    w_dec_sat  = 1'b0;
    if (w_e == 8'd0) begin
      w_dec_mag = 32'd0;
    end else if (w_e == 8'hFF) begin
      w_dec_sat = 1'b1;
      w_dec_mag = (w_mant != 23'd0) ? c_pos_sat : w_sat_val;
    end else if ((w_k > 10'sd8) || ((w_k == 10'sd8) && !w_exact_min)) begin
      w_dec_sat = 1'b1;
      w_dec_mag = w_sat_val;
    end else if (w_k >= 10'sd0) begin
      w_dec_mag  = {8'd0, w_sig};
      w_dec_n    = w_k[4:0];
      w_dec_left = 1'b1;
    end else if (w_k >= -10'sd23) begin
      w_dec_mag  = {8'd0, w_sig};
      w_dec_n    = w_rn;
      w_dec_left = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_float <= 32'd0;
      r_exp   <= 8'd0;
      r_mag   <= 32'd0;
      r_cnt   <= 5'd0;
      r_left  <= 1'b0;
      r_sat   <= 1'b0;
      r_fixed <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctl.load_new) begin
            r_float <= ctl.float_in;
            r_exp   <= ctl.exp_in;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_mag   <= w_dec_mag;
          r_cnt   <= w_dec_n;
          r_left  <= w_dec_left;
          r_sat   <= w_dec_sat;
          r_state <= (w_dec_n != 5'd0) ? S_SHIFT : S_SIGN;
        end
        S_SHIFT: begin
          r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          // Saturated values are already signed; a zero magnitude negates to 0.
          r_fixed <= r_sat ? r_mag : (w_sign ? (32'd0 - r_mag) : r_mag);
          r_ovf   <= r_sat;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ctl.fixed    = r_fixed;
  assign ctl.busy     = r_busy;
  assign ctl.done     = r_done;
  assign ctl.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_float_to_fixed.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_to_fixed
// Description : Scoreboard bench for float_to_fixed with a numeric reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_fixed;

  typedef struct {
    logic [31:0] fx;
    logic        ov;
    int          done_cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t mon_ent;
  logic prev_done;

  float_to_fixed_if ffi ();

  float_to_fixed dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ffi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Reference: value = sig * 2^(e-150), divided by 2^exp_in, truncated toward zero.
  function automatic void model(input logic [31:0] f, input logic [7:0] x,
                                output logic [31:0] fx, output logic ov, output int lat);
    int     e;
    int     sh;
    longint sig;
    longint mag;
    longint val;
    e   = int'(f[30:23]);
    sig = longint'({1'b1, f[22:0]});
    fx  = 32'd0;
    ov  = 1'b0;
    lat = 2;
    if (e == 0) begin
      fx = 32'd0;
    end else if (e == 255) begin
      ov = 1'b1;
      fx = (f[22:0] != 0 || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    end else begin
      sh = e - 150 - int'($signed(x));
      if (sh > 32) begin
        ov = 1'b1;
        fx = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        if (sh >= 0) begin
          mag = sig << sh;
          lat = 2 + sh;
        end else if (sh >= -23) begin
          mag = sig >> (-sh);
          lat = 2 - sh;
        end else begin
          mag = 0;
        end
        val = f[31] ? -mag : mag;
        if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
          ov  = 1'b1;
          lat = 2;
          fx  = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
          fx = val[31:0];
        end
      end
    end
  endfunction

  function automatic void push_exp(input logic [31:0] f, input logic [7:0] x, input int acc);
    exp_t ent;
    int   lat;
    model(f, x, ent.fx, ent.ov, lat);
    ent.done_cyc = acc + lat;
    sb.push_back(ent);
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (ffi.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ffi.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy stuck at %b, required 0", ffi.busy);
    end
  endtask

  task automatic issue(input logic [31:0] f, input logic [7:0] x);
    int acc;
    wait_idle();
    ffi.float_in = f;
    ffi.exp_in   = x;
    ffi.load_new = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    ffi.load_new = 1'b0;
    push_exp(f, x, acc);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ffi.done && !prev_done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          mon_ent = sb.pop_front();
          chk("fixed", ffi.fixed, mon_ent.fx);
          chk("overflow", {31'd0, ffi.overflow}, {31'd0, mon_ent.ov});
          chk("latency_cycle", cyc, mon_ent.done_cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done by cycle %0d expected at %0d", cyc, sb[0].done_cyc);
        void'(sb.pop_front());
      end
    end
    prev_done = ffi.done;
  end

  initial begin
    int          a1;
    int          a2;
    int          l1;
    logic [31:0] tf;
    logic        tov;
    logic [31:0] rf;
    logic [7:0]  rx;
    logic [7:0]  re;
    int          r;

    n_vec        = 0;
    n_err        = 0;
    prev_done    = 1'b0;
    reset        = 1'b1;
    ffi.float_in = 32'd0;
    ffi.exp_in   = 8'd0;
    ffi.load_new = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_fixed", ffi.fixed, 32'd0);
    chk("reset_busy", {31'd0, ffi.busy}, 32'd0);
    chk("reset_done", {31'd0, ffi.done}, 32'd0);
    chk("reset_overflow", {31'd0, ffi.overflow}, 32'd0);
    reset = 1'b0;

    issue(32'h3F80_0000, 8'h00);
    issue(32'h4000_0000, 8'h01);
    issue(32'h40D0_0000, 8'hFF);
    issue(32'hBF80_0000, 8'h00);
    issue(32'h4F00_0000, 8'h00);
    issue(32'hCF00_0000, 8'h00);
    issue(32'h4E80_0000, 8'h00);
    issue(32'h3F40_0000, 8'h00);
    issue(32'hBFC0_0000, 8'h00);
    issue(32'h7FC0_0000, 8'h00);
    issue(32'h0000_0001, 8'h00);
    issue(32'hFF80_0000, 8'h00);

    // A load request while busy must not disturb the running conversion.
    issue(32'h3F80_0000, 8'h00);
    repeat (3) @(negedge clk);
    ffi.float_in = 32'h4E80_0000;
    ffi.exp_in   = 8'h05;
    ffi.load_new = 1'b1;
    @(negedge clk);
    ffi.load_new = 1'b0;

    // load_new held across completion: back-to-back runs.
    wait_idle();
    ffi.float_in = 32'h40D0_0000;
    ffi.exp_in   = 8'hFF;
    ffi.load_new = 1'b1;
    @(posedge clk);
    #1;
    a1 = cyc;
    model(32'h40D0_0000, 8'hFF, tf, tov, l1);
    push_exp(32'h40D0_0000, 8'hFF, a1);
    ffi.float_in = 32'hBF80_0000;
    ffi.exp_in   = 8'h00;
    a2 = a1 + l1 + 1;
    push_exp(32'hBF80_0000, 8'h00, a2);
    while (cyc < a2) @(negedge clk);
    chk("held_done_drop", {31'd0, ffi.done}, 32'd0);
    chk("held_busy_rise", {31'd0, ffi.busy}, 32'd1);
    ffi.load_new = 1'b0;

    // Asynchronous reset in the middle of a shift sequence.
    issue(32'h3F80_0000, 8'h00);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_fixed", ffi.fixed, 32'd0);
    chk("midreset_busy", {31'd0, ffi.busy}, 32'd0);
    chk("midreset_done", {31'd0, ffi.done}, 32'd0);
    chk("midreset_overflow", {31'd0, ffi.overflow}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    issue(32'h3F80_0000, 8'h00);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      re = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : 8'($urandom_range(100, 170));
      rf = {1'($urandom), re, 23'($urandom)};
      rx = 8'($urandom_range(0, 40));
      rx = rx - 8'd20;
      issue(rf, rx);
    end

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
